// File: rtl/mor1kx_dpram_pkg.sv
// Shared types and helpers for the multi-read-port single-clock RAM.
// Clear-engine state encoding and byte-enable width calculation.
package mor1kx_dpram_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_e;

   function automatic int calc_bew(input int data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/mor1kx_dpram_bypass_lane.sv
// One read-port output stage: captures colliding write data and merges it
// byte-by-byte over the registered array read.
module mor1kx_dpram_bypass_lane
   import mor1kx_dpram_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int BEW        = calc_bew(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_rd_en,
   input  logic                  i_hit,
   input  logic [DATA_WIDTH-1:0] i_din,
   input  logic [BEW-1:0]        i_wbe,
   input  logic [DATA_WIDTH-1:0] i_rdata,
   output logic [DATA_WIDTH-1:0] o_dout
);

   logic [DATA_WIDTH-1:0] r_din;
   logic [BEW-1:0]        r_mask;
   logic                  r_byp;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_din  <= '0;
         r_mask <= '0;
         r_byp  <= 1'b0;
      end else if (i_rd_en) begin
         r_byp <= i_hit;
         if (i_hit) begin
            r_din  <= i_din;
            r_mask <= i_wbe;
         end
      end
   end

   // The array read returned pre-write data; overlay only the written bytes.
   always_comb begin
      o_dout = i_rdata;
      for (int k = 0; k < BEW; k++)
         if (r_byp && r_mask[k])
            o_dout[8*k +: 8] = r_din[8*k +: 8];
   end

endmodule

// File: rtl/mor1kx_dpram_sclk_mp.sv
// Single-clock RAM: one byte-maskable write port, NUM_RPORTS read ports,
// optional write-to-read bypass and a sequential clear engine.
module mor1kx_dpram_sclk_mp
   import mor1kx_dpram_pkg::*;
#(
   parameter int                    ADDR_WIDTH     = 8,
   parameter int                    DATA_WIDTH     = 32,
   parameter int                    NUM_RPORTS     = 2,
   parameter int                    ENABLE_BYPASS  = 1,
   parameter int                    CLEAR_ON_RESET = 1,
   parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] raddr,
   input  logic [NUM_RPORTS-1:0]            re,
   input  logic [ADDR_WIDTH-1:0]            waddr,
   input  logic                             we,
   input  logic [DATA_WIDTH/8-1:0]          wbe,
   input  logic [DATA_WIDTH-1:0]            din,
   output logic [NUM_RPORTS*DATA_WIDTH-1:0] dout,
   input  logic                             flush,
   output logic                             busy
);

   localparam int BEW   = calc_bew(DATA_WIDTH);
   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   clr_state_e            r_state, w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_clr_addr, w_clr_addr_nxt;
   logic                  w_clr;

   assign w_clr = (r_state == CLEAR);
   assign busy  = w_clr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
         r_clr_addr <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_clr_addr <= w_clr_addr_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_clr_addr_nxt = r_clr_addr;
      case (r_state)
         IDLE: begin
            if (flush) begin
               w_state_nxt    = CLEAR;
               w_clr_addr_nxt = '0;
            end
         end
         CLEAR: begin
            if (flush) begin
               w_clr_addr_nxt = '0;
            end else if (r_clr_addr == {ADDR_WIDTH{1'b1}}) begin
               w_state_nxt    = IDLE;
               w_clr_addr_nxt = '0;
            end else begin
               w_clr_addr_nxt = r_clr_addr + 1'b1;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // The clear engine owns the write port for the whole sweep.
   logic                  w_wr_en;
   logic [ADDR_WIDTH-1:0] w_wr_addr;
   logic [DATA_WIDTH-1:0] w_wr_data;
   logic [BEW-1:0]        w_wr_be;

   assign w_wr_en   = w_clr | we;
   assign w_wr_addr = w_clr ? r_clr_addr  : waddr;
   assign w_wr_data = w_clr ? CLEAR_VALUE : din;
   assign w_wr_be   = w_clr ? {BEW{1'b1}} : wbe;

   always_ff @(posedge clk) begin
      if (w_wr_en)
         for (int k = 0; k < BEW; k++)
            if (w_wr_be[k])
               r_mem[w_wr_addr][8*k +: 8] <= w_wr_data[8*k +: 8];
   end

   for (genvar i = 0; i < NUM_RPORTS; i++) begin : g_port
      logic [ADDR_WIDTH-1:0] w_raddr;
      logic                  w_rd_en;
      logic                  w_hit;
      logic [DATA_WIDTH-1:0] r_rdata;
      logic [DATA_WIDTH-1:0] w_dout;

      assign w_raddr = raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_rd_en = re[i] & ~w_clr;
      assign w_hit   = (ENABLE_BYPASS != 0) && we && (w_raddr == waddr);

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n)
            r_rdata <= '0;
         else if (w_rd_en)
            r_rdata <= r_mem[w_raddr];
      end

      mor1kx_dpram_bypass_lane #(
         .DATA_WIDTH (DATA_WIDTH),
         .BEW        (BEW)
      ) u_lane (
         .clk     (clk),
         .rst_n   (rst_n),
         .i_rd_en (w_rd_en),
         .i_hit   (w_hit),
         .i_din   (din),
         .i_wbe   (wbe),
         .i_rdata (r_rdata),
         .o_dout  (w_dout)
      );

      assign dout[i*DATA_WIDTH +: DATA_WIDTH] = w_dout;
   end

endmodule

// File: tb/tb_mor1kx_dpram_sclk_mp.sv
// Directed bench for mor1kx_dpram_sclk_mp: a bypass-enabled and a
// bypass-disabled instance share every input.
module tb_mor1kx_dpram_sclk_mp;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  raddr;
   logic [1:0]  re;
   logic [3:0]  waddr;
   logic        we;
   logic [3:0]  wbe;
   logic [31:0] din;
   logic [63:0] dout, dout_nb;
   logic        flush;
   logic        busy, busy_nb;

   int n_vec = 0;
   int n_err = 0;
   int cnt;

   always #5 clk = ~clk;

   mor1kx_dpram_sclk_mp #(
      .ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_RPORTS(2),
      .ENABLE_BYPASS(1), .CLEAR_ON_RESET(1), .CLEAR_VALUE(32'h0)
   ) dut (
      .clk(clk), .rst_n(rst_n), .raddr(raddr), .re(re), .waddr(waddr),
      .we(we), .wbe(wbe), .din(din), .dout(dout), .flush(flush), .busy(busy)
   );

   mor1kx_dpram_sclk_mp #(
      .ADDR_WIDTH(4), .DATA_WIDTH(32), .NUM_RPORTS(2),
      .ENABLE_BYPASS(0), .CLEAR_ON_RESET(1), .CLEAR_VALUE(32'h0)
   ) dut_nb (
      .clk(clk), .rst_n(rst_n), .raddr(raddr), .re(re), .waddr(waddr),
      .we(we), .wbe(wbe), .din(din), .dout(dout_nb), .flush(flush), .busy(busy_nb)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
      waddr = a; din = d; wbe = be; we = 1'b1;
      tick();
      we = 1'b0;
   endtask

   task automatic rd(input logic [3:0] a0, input logic [3:0] a1);
      raddr = {a1, a0}; re = 2'b11;
      tick();
      re = 2'b00;
   endtask

   // Counts edges (including any already taken) until busy drops, bounded.
   task automatic count_busy(input int start, output int n);
      n = start;
      while (busy && n < 100) begin
         tick();
         if (busy) n++;
      end
   endtask

   initial begin
      rst_n = 1'b0; raddr = '0; re = '0; waddr = '0; we = 1'b0;
      wbe = '0; din = '0; flush = 1'b0;
      repeat (3) tick();
      chk("rst_dout0", dout[31:0], 32'h0);
      chk("rst_dout1", dout[63:32], 32'h0);
      chk("rst_busy", {31'b0, busy}, 32'h1);

      // Reset release: 16-entry sweep
      rst_n = 1'b1;
      cnt = 0;
      while (busy && cnt < 100) begin
         tick();
         cnt++;
      end
      chk("por_busy_cycles", cnt, 16);
      for (int a = 0; a < 16; a++) begin
         rd(a[3:0], 4'(15 - a));
         chk("por_clear_p0", dout[31:0], 32'h0);
         chk("por_clear_p1", dout[63:32], 32'h0);
      end

      // Byte-enable merge and wbe=0 no-op
      wr(4'd3, 32'hDEADBEEF, 4'b1111);
      wr(4'd3, 32'h000000AA, 4'b0001);
      wr(4'd3, 32'hFFFFFFFF, 4'b0000);
      rd(4'd3, 4'd3);
      chk("bytemerge_p0", dout[31:0], 32'hDEADBEAA);
      chk("bytemerge_p1", dout[63:32], 32'hDEADBEAA);

      // Colliding write/read: bypass vs. read-old-data
      wr(4'd5, 32'h11223344, 4'b1111);
      waddr = 4'd5; din = 32'hAABBCCDD; wbe = 4'b0110; we = 1'b1;
      raddr = {4'd5, 4'd5}; re = 2'b11;
      tick();
      we = 1'b0; re = 2'b00;
      chk("bypass_p0", dout[31:0], 32'h11BBCC44);
      chk("bypass_p1", dout[63:32], 32'h11BBCC44);
      chk("nobypass_p0", dout_nb[31:0], 32'h11223344);
      chk("nobypass_p1", dout_nb[63:32], 32'h11223344);
      rd(4'd5, 4'd5);
      chk("postwrite_nb", dout_nb[31:0], 32'h11BBCC44);
      chk("postwrite_byp", dout[63:32], 32'h11BBCC44);

      // Independent ports, then hold with re=0
      wr(4'd2, 32'h22222222, 4'b1111);
      wr(4'd7, 32'h77777777, 4'b1111);
      rd(4'd2, 4'd7);
      chk("concur_p0", dout[31:0], 32'h22222222);
      chk("concur_p1", dout[63:32], 32'h77777777);
      raddr = {4'd3, 4'd5};
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("hold_p0", dout[31:0], 32'h22222222);
         chk("hold_p1", dout[63:32], 32'h77777777);
      end

      // Flush, restart 6 edges in, external traffic during busy is dropped
      wr(4'd1, 32'h12345678, 4'b1111);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      chk("flush_busy", {31'b0, busy}, 32'h1);
      waddr = 4'd8; din = 32'h88888888; wbe = 4'b1111; we = 1'b1;
      raddr = {4'd8, 4'd1}; re = 2'b11;
      repeat (5) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      count_busy(7, cnt);
      we = 1'b0; re = 2'b00;
      chk("flush_busy_cycles", cnt, 22);
      chk("busy_hold_p0", dout[31:0], 32'h22222222);
      chk("busy_hold_p1", dout[63:32], 32'h77777777);
      for (int a = 0; a < 16; a++) begin
         rd(a[3:0], a[3:0]);
         chk("flush_clear", dout[31:0], 32'h0);
      end

      // Reset in the middle of a sweep
      wr(4'd4, 32'hCAFEF00D, 4'b1111);
      rd(4'd4, 4'd4);
      chk("pre_rst_p0", dout[31:0], 32'hCAFEF00D);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      repeat (9) tick();
      rst_n = 1'b0;
      #1;
      chk("midrst_dout0", dout[31:0], 32'h0);
      chk("midrst_dout1", dout[63:32], 32'h0);
      chk("midrst_busy", {31'b0, busy}, 32'h1);
      repeat (2) tick();
      rst_n = 1'b1;
      count_busy(1, cnt);
      chk("midrst_sweep_cycles", cnt, 16);
      chk("post_sweep_idle", {31'b0, busy}, 32'h0);
      rd(4'd4, 4'd15);
      chk("post_sweep_p0", dout[31:0], 32'h0);
      chk("post_sweep_p1", dout[63:32], 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mor1kx_dpram_sclk_mp.md
# mor1kx_dpram_sclk_mp

Single-clock RAM with one write port and NUM_RPORTS independent read ports. It adds per-byte write enables, per-port byte-merging write-to-read bypass, and a hardware clear engine that initialises every entry after reset or on request. It is the next-generation storage primitive for mor1kx cache tag/data arrays and register files that need several read ports and guaranteed-known contents after reset.

## Interface
Parameters:
- ADDR_WIDTH, 8, address bits; depth = 2^ADDR_WIDTH
- DATA_WIDTH, 32, word width; must be a multiple of 8
- NUM_RPORTS, 2, number of read ports (1..4)
- ENABLE_BYPASS, 1, enables per-port byte-merging write-to-read bypass
- CLEAR_ON_RESET, 1, starts a clear sweep when reset is released
- CLEAR_VALUE, 0, DATA_WIDTH value written to every entry by the clear engine

Ports (BEW = DATA_WIDTH/8):
- clk  in  1  clock; all state is updated on the rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- raddr  in  NUM_RPORTS*ADDR_WIDTH  read addresses; port i uses slice [i*ADDR_WIDTH +: ADDR_WIDTH]
- re  in  NUM_RPORTS  read enable per port
- waddr  in  ADDR_WIDTH  write address
- we  in  1  write enable
- wbe  in  BEW  byte enables for the write; bit k covers din[8k+7:8k]
- din  in  DATA_WIDTH  write data
- dout  out  NUM_RPORTS*DATA_WIDTH  read data; port i uses slice [i*DATA_WIDTH +: DATA_WIDTH]
- flush  in  1  one-cycle request to start a clear sweep
- busy  out  1  a clear sweep is in progress

## Operation
- Clear FSM states:
  - IDLE: normal operation.
  - CLEAR: a counter clr_addr walks 0 to 2^ADDR_WIDTH-1, writing CLEAR_VALUE with all bytes enabled, one entry per cycle.
- Transitions:
  - Reset moves the FSM to CLEAR if CLEAR_ON_RESET=1, otherwise to IDLE. clr_addr resets to 0.
  - IDLE -> CLEAR when flush=1. clr_addr is set to 0.
  - CLEAR -> IDLE after the cycle that writes address 2^ADDR_WIDTH-1. The counter wraps to 0.
  - flush=1 while in CLEAR restarts the sweep: clr_addr is set to 0 on the next edge.
- busy=1 exactly while the FSM is in CLEAR.
- While busy: external we and re are ignored, and dout holds its value.
- Write (IDLE, we=1): for each k, if wbe[k]=1, then mem[waddr] byte k <= din byte k. Bytes with wbe[k]=0 are unchanged. we=1 with wbe=0 is a no-op.
- Read (IDLE, re[i]=1): rdata_i <= mem[raddr_i] as it was before this edge's write (read-old-data). With re[i]=0, dout_i holds.
- Bypass (ENABLE_BYPASS=1):
  - Condition: on an edge with re[i], we, and raddr_i==waddr all true.
  - Port i registers din, registers the byte mask wbe, and sets bypass_i.
  - dout_i byte k = din_r byte k where the registered mask bit is 1, else rdata_i byte k. The result equals the post-write contents.
  - The next edge with re[i]=1 and no collision clears bypass_i.
- ENABLE_BYPASS=0: dout_i = rdata_i. A colliding read returns the old data.
- Several ports may read the same address in one cycle; each behaves independently.
- mem contents are not reset. Only the clear engine defines them.

## Timing
- Read latency: 1 cycle, from re at edge n to valid dout at edge n+1.
- Write latency: 1 cycle. A read issued on the edge after the write returns the new data.
- Clear sweep: takes exactly 2^ADDR_WIDTH cycles. busy falls on the edge that completes the last write.
- With flush at edge n in IDLE, busy=1 from edge n through the sweep.
- Reset values: dout=0 on all ports, bypass flags=0, busy=CLEAR_ON_RESET.
- Reset asserted mid-sweep: the sweep aborts asynchronously. After release it restarts from address 0 if CLEAR_ON_RESET=1; otherwise the array is left partially cleared.
- No combinational path from any input to dout or busy.

## Structure
- The package mor1kx_dpram_pkg holds:
  - the clear-FSM state encoding: IDLE=1'b0, CLEAR=1'b1
  - a function that computes BEW from DATA_WIDTH.
- Sub-module mor1kx_dpram_bypass_lane: one instance per read port, generated. It holds din_r, the mask register, the bypass flag and the byte-merge mux.
- The top level holds the memory array, the write mux (clear versus external), per-port rdata registers, and the clear FSM/counter.

## Test plan
- Reset release, CLEAR_ON_RESET=1, ADDR_WIDTH=4 -> busy=1 for exactly 16 cycles, then 0; every address reads 0; dout=0 during reset.
- Write 0xDEADBEEF to addr 3 with wbe=4'b1111, then write 0x000000AA to addr 3 with wbe=4'b0001; read addr 3 -> 0xDEADBEAA.
- Set addr 5 = 0x11223344. Then, in the same cycle, write 0xAABBCCDD with wbe=4'b0110 and read addr 5 on ports 0 and 1 -> both dout = 0x11BBCC44 next cycle. With ENABLE_BYPASS=0 -> 0x11223344.
- Ports read addr 2 and addr 7 concurrently, then re=0 for 3 cycles -> both douts correct after 1 cycle and held while re=0.
- flush in IDLE; flush again at sweep address 6; we/re driven during busy -> sweep restarts from 0; busy lasts 16+6 cycles total from the first flush; driven writes are dropped; dout unchanged; all entries = CLEAR_VALUE afterwards.
- rst_n asserted at sweep address 9 -> busy and dout go to their reset values immediately; a full 16-cycle sweep follows release.
